// File: rtl/piso_pkg.sv
// -----------------------------------------------------------------------------
// piso_pkg
// Shared types and defaults for the parallel-in/serial-out serializer.
//   piso_state_t        : FSM state encoding (IDLE, SHIFT)
//   DEFAULT_DATA_WIDTH  : default serialized word width in bits
// -----------------------------------------------------------------------------
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    localparam int DEFAULT_DATA_WIDTH = 8;

endpackage : piso_pkg

// File: rtl/piso_serializer_8_bit.sv
// -----------------------------------------------------------------------------
// piso_serializer_8_bit
// Parallel-in/serial-out shift register with a valid/ready load handshake.
// A word accepted at a rising edge drives its first bit from that same edge,
// and the following DATA_WIDTH-1 bits go out on consecutive cycles. A new
// word may be accepted during the last-bit cycle, so words stream with no gap.
//
// Parameters:
//   DATA_WIDTH   word width in bits (>= 2)
//   MSB_FIRST    1: bit DATA_WIDTH-1 goes out first, 0: bit 0 goes out first
//
// Ports:
//   Clk_In            in   clock, rising edge
//   Reset_In          in   asynchronous active-low reset
//   Parallel_Data_In  in   word to serialize, sampled on an accepted load
//   Load_Valid_In     in   producer offers a word
//   Load_Ready_Out    out  a word can be accepted this cycle (combinational)
//   Serial_Data_Out   out  current serial bit, 0 when not valid
//   Serial_Valid_Out  out  Serial_Data_Out carries a data bit
//   Serial_First_Out  out  first bit of a word
//   Serial_Last_Out   out  last bit of a word
//   Busy_Out          out  a word is in flight (same as Serial_Valid_Out)
// -----------------------------------------------------------------------------
module piso_serializer_8_bit
    import piso_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  Clk_In,
    input  logic                  Reset_In,
    input  logic [DATA_WIDTH-1:0] Parallel_Data_In,
    input  logic                  Load_Valid_In,
    output logic                  Load_Ready_Out,
    output logic                  Serial_Data_Out,
    output logic                  Serial_Valid_Out,
    output logic                  Serial_First_Out,
    output logic                  Serial_Last_Out,
    output logic                  Busy_Out
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    piso_state_t           state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;

    logic                  in_shift;
    logic                  at_last;
    logic                  accept;
    logic [DATA_WIDTH-1:0] shifted;
    logic                  head_bit;

    // Shift direction is fixed at elaboration: the bit on the output is
    // always the "head" end of the register, and the register moves toward it.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign shifted  = {shift_q[DATA_WIDTH-2:0], 1'b0};
            assign head_bit = shift_q[DATA_WIDTH-1];
        end else begin : g_lsb_first
            assign shifted  = {1'b0, shift_q[DATA_WIDTH-1:1]};
            assign head_bit = shift_q[0];
        end
    endgenerate

    // Handshake: ready in IDLE and on the last-bit cycle. Gating with the
    // reset input keeps ready low for the whole time reset is asserted.
    always_comb begin
        in_shift       = (state_q == SHIFT);
        at_last        = in_shift && (cnt_q == LAST_CNT);
        Load_Ready_Out = Reset_In && (!in_shift || at_last);
        accept         = Load_Valid_In && Load_Ready_Out;
    end

    // ---------------------------------------------------------------------
    // State register (plus datapath registers)
    // ---------------------------------------------------------------------
    always_ff @(posedge Clk_In or negedge Reset_In) begin
        if (!Reset_In) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // A reload on the last bit keeps streaming without a gap.
                if (at_last && !accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: load, shift, or clear after the final bit.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (accept) begin
            shift_d = Parallel_Data_In;
            cnt_d   = '0;
        end else if (at_last) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (in_shift) begin
            shift_d = shifted;
            cnt_d   = cnt_q + CNT_ONE;
        end
    end

    // ---------------------------------------------------------------------
    // Output logic
    // ---------------------------------------------------------------------
    always_comb begin
        Serial_Valid_Out = in_shift;
        Serial_Data_Out  = in_shift && head_bit;
        Serial_First_Out = in_shift && (cnt_q == '0);
        Serial_Last_Out  = at_last;
        Busy_Out         = in_shift;
    end

endmodule : piso_serializer_8_bit

// File: tb/tb_piso_serializer_8_bit.sv
// -----------------------------------------------------------------------------
// tb_piso_serializer_8_bit
// Directed bench for piso_serializer_8_bit. Two instances share all inputs:
// u_msb (MSB_FIRST=1) and u_lsb (MSB_FIRST=0). Inputs change and outputs are
// observed on the falling clock edge; the design acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_piso_serializer_8_bit;

    logic       clk;
    logic       rst_n;
    logic [7:0] pdata;
    logic       lvalid;

    logic m_ready, m_data, m_valid, m_first, m_last, m_busy;
    logic l_ready, l_data, l_valid, l_first, l_last, l_busy;

    int total;
    int bad;

    piso_serializer_8_bit #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .Clk_In           (clk),
        .Reset_In         (rst_n),
        .Parallel_Data_In (pdata),
        .Load_Valid_In    (lvalid),
        .Load_Ready_Out   (m_ready),
        .Serial_Data_Out  (m_data),
        .Serial_Valid_Out (m_valid),
        .Serial_First_Out (m_first),
        .Serial_Last_Out  (m_last),
        .Busy_Out         (m_busy)
    );

    piso_serializer_8_bit #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .Clk_In           (clk),
        .Reset_In         (rst_n),
        .Parallel_Data_In (pdata),
        .Load_Valid_In    (lvalid),
        .Load_Ready_Out   (l_ready),
        .Serial_Data_Out  (l_data),
        .Serial_Valid_Out (l_valid),
        .Serial_First_Out (l_first),
        .Serial_Last_Out  (l_last),
        .Busy_Out         (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n  = 1'b0;
        pdata  = 8'h00;
        lvalid = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({m_ready, m_data, m_valid, m_first, m_last, m_busy} !== 6'b0) begin
            bad++;
            $display("FAIL reset_msb_outputs got=%b want=000000",
                     {m_ready, m_data, m_valid, m_first, m_last, m_busy});
        end
        total++;
        if ({l_ready, l_data, l_valid, l_first, l_last, l_busy} !== 6'b0) begin
            bad++;
            $display("FAIL reset_lsb_outputs got=%b want=000000",
                     {l_ready, l_data, l_valid, l_first, l_last, l_busy});
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (m_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready got=%b want=1", m_ready);
        end
        $display("test_reset: done");
    endtask

    // 8'hA5 MSB first -> 1,0,1,0,0,1,0,1
    task automatic test_msb_a5();
        logic [7:0] exp_bits;
        exp_bits = 8'b1010_0101;  // index 7-k gives bit k in send order
        @(negedge clk);
        pdata  = 8'hA5;
        lvalid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) lvalid = 1'b0;
            total++;
            if ({m_valid, m_busy, m_data, m_first, m_last} !==
                {1'b1, 1'b1, exp_bits[7-k], (k == 0), (k == 7)}) begin
                bad++;
                $display("FAIL a5_bit%0d got v/b/d/f/l=%b%b%b%b%b want=11%b%b%b",
                         k, m_valid, m_busy, m_data, m_first, m_last,
                         exp_bits[7-k], (k == 0), (k == 7));
            end
        end
        @(negedge clk);
        total++;
        if ({m_valid, m_data, m_first, m_last, m_busy, m_ready} !== 6'b000001) begin
            bad++;
            $display("FAIL a5_idle_after got=%b want=000001",
                     {m_valid, m_data, m_first, m_last, m_busy, m_ready});
        end
        $display("test_msb_a5: word A5 checked");
    endtask

    // 8'h3C then 8'hC3 reloaded on the last bit -> 16 contiguous bits
    task automatic test_back_to_back();
        logic [15:0] exp_bits;
        exp_bits = 16'b0011_1100_1100_0011;
        pdata  = 8'h3C;
        lvalid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            total++;
            if ({m_valid, m_data, m_first, m_last} !==
                {1'b1, exp_bits[15-k], (k == 0 || k == 8), (k == 7 || k == 15)}) begin
                bad++;
                $display("FAIL b2b_bit%0d got v/d/f/l=%b%b%b%b want=1%b%b%b",
                         k, m_valid, m_data, m_first, m_last, exp_bits[15-k],
                         (k == 0 || k == 8), (k == 7 || k == 15));
            end
            if (k == 0 || k == 8) lvalid = 1'b0;
            if (k == 7) begin
                total++;
                if (m_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_ready_last got=%b want=1", m_ready);
                end
                pdata  = 8'hC3;
                lvalid = 1'b1;
            end
        end
        @(negedge clk);
        total++;
        if (m_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle_after got=%b want=0", m_valid);
        end
        $display("test_back_to_back: words 3C,C3 checked");
    endtask

    // 8'h01 on the LSB-first instance -> 1,0,0,0,0,0,0,0
    task automatic test_lsb_first();
        logic [7:0] exp_lsb;
        logic [7:0] exp_msb;
        exp_lsb = 8'b1000_0000;  // index 7-k, send order
        exp_msb = 8'b0000_0001;
        pdata  = 8'h01;
        lvalid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) lvalid = 1'b0;
            total++;
            if ({l_valid, l_data, l_first, l_last} !==
                {1'b1, exp_lsb[7-k], (k == 0), (k == 7)}) begin
                bad++;
                $display("FAIL lsb01_bit%0d got v/d/f/l=%b%b%b%b want=1%b%b%b",
                         k, l_valid, l_data, l_first, l_last, exp_lsb[7-k],
                         (k == 0), (k == 7));
            end
            total++;
            if (m_data !== exp_msb[7-k]) begin
                bad++;
                $display("FAIL msb01_bit%0d got=%b want=%b", k, m_data, exp_msb[7-k]);
            end
        end
        @(negedge clk);
        total++;
        if (l_valid !== 1'b0) begin
            bad++;
            $display("FAIL lsb01_idle_after got=%b want=0", l_valid);
        end
        $display("test_lsb_first: word 01 checked");
    endtask

    // 8'h0F in flight while 8'hFF is offered early; FF only accepted on last bit
    task automatic test_hold_off();
        logic [15:0] exp_bits;
        exp_bits = 16'b0000_1111_1111_1111;
        pdata  = 8'h0F;
        lvalid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            total++;
            if ({m_valid, m_data, m_first} !==
                {1'b1, exp_bits[15-k], (k == 0 || k == 8)}) begin
                bad++;
                $display("FAIL hold_bit%0d got v/d/f=%b%b%b want=1%b%b",
                         k, m_valid, m_data, m_first, exp_bits[15-k],
                         (k == 0 || k == 8));
            end
            if (k < 8) begin
                total++;
                if (m_ready !== (k == 7)) begin
                    bad++;
                    $display("FAIL hold_ready_bit%0d got=%b want=%b", k, m_ready, (k == 7));
                end
            end
            if (k == 0) pdata = 8'hFF;  // valid stays high from here
            if (k == 8) lvalid = 1'b0;
        end
        @(negedge clk);
        total++;
        if (m_valid !== 1'b0) begin
            bad++;
            $display("FAIL hold_idle_after got=%b want=0", m_valid);
        end
        $display("test_hold_off: words 0F,FF checked");
    endtask

    // Reset after 3 bits of 8'hF0, then 8'h81 -> 1,0,0,0,0,0,0,1
    task automatic test_reset_mid_word();
        logic [7:0] exp_bits;
        exp_bits = 8'b1000_0001;
        pdata  = 8'hF0;
        lvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) lvalid = 1'b0;
            total++;
            if ({m_valid, m_data} !== 2'b11) begin
                bad++;
                $display("FAIL f0_bit%0d got v/d=%b%b want=11", k, m_valid, m_data);
            end
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({m_ready, m_data, m_valid, m_first, m_last, m_busy} !== 6'b0) begin
            bad++;
            $display("FAIL midreset_outputs got=%b want=000000",
                     {m_ready, m_data, m_valid, m_first, m_last, m_busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if ({m_ready, m_valid} !== 2'b10) begin
            bad++;
            $display("FAIL midreset_release got ready/valid=%b want=10", {m_ready, m_valid});
        end
        pdata  = 8'h81;
        lvalid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) lvalid = 1'b0;
            total++;
            if ({m_valid, m_data, m_first, m_last} !==
                {1'b1, exp_bits[7-k], (k == 0), (k == 7)}) begin
                bad++;
                $display("FAIL r81_bit%0d got v/d/f/l=%b%b%b%b want=1%b%b%b",
                         k, m_valid, m_data, m_first, m_last, exp_bits[7-k],
                         (k == 0), (k == 7));
            end
        end
        @(negedge clk);
        $display("test_reset_mid_word: F0 aborted, 81 checked");
    endtask

    // Input changes after acceptance of 8'hAA must not affect the output
    task automatic test_data_change();
        logic [7:0] exp_bits;
        exp_bits = 8'b1010_1010;
        pdata  = 8'hAA;
        lvalid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                lvalid = 1'b0;
                pdata  = 8'h00;
            end
            total++;
            if ({m_valid, m_data} !== {1'b1, exp_bits[7-k]}) begin
                bad++;
                $display("FAIL aa_bit%0d got v/d=%b%b want=1%b",
                         k, m_valid, m_data, exp_bits[7-k]);
            end
        end
        @(negedge clk);
        total++;
        if (m_valid !== 1'b0) begin
            bad++;
            $display("FAIL aa_idle_after got=%b want=0", m_valid);
        end
        $display("test_data_change: word AA checked");
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_msb_a5();
        test_back_to_back();
        test_lsb_first();
        test_hold_off();
        test_reset_mid_word();
        test_data_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_piso_serializer_8_bit

// File: doc/piso_serializer_8_bit.md
Name: piso_serializer_8_bit

Overview:
- Parallel-in/serial-out shift register with a valid/ready load handshake. It is the transmit end feeding a serial-in/parallel-out receiver.
- Captures a DATA_WIDTH-bit word and shifts it out one bit per clock, with framing strobes marking the first and last bit.
- Back-to-back words stream with no idle cycles. It sits between a parallel producer and a serial link or deserializer.

Parameters:
- DATA_WIDTH, 8: word width in bits; legal values are 2 or more.
- MSB_FIRST, 1: 1 shifts bit DATA_WIDTH-1 first; 0 shifts bit 0 first.

Ports:
- Clk_In  input  1  single clock; all state updates on the rising edge.
- Reset_In  input  1  asynchronous, active-low reset.
- Parallel_Data_In  input  DATA_WIDTH  word to serialize; sampled only on an accepted load.
- Load_Valid_In  input  1  producer has a word on Parallel_Data_In.
- Load_Ready_Out  output  1  block can accept a word this cycle.
- Serial_Data_Out  output  1  current serial bit; 0 when Serial_Valid_Out=0.
- Serial_Valid_Out  output  1  Serial_Data_Out carries a data bit.
- Serial_First_Out  output  1  high on the first bit of each word.
- Serial_Last_Out  output  1  high on the last bit of each word.
- Busy_Out  output  1  a word is in flight (equals Serial_Valid_Out).

Behaviour:
- Reset (Reset_In=0, asynchronous):
  - State=IDLE, shift register=0, bit counter=0.
  - Serial_Data_Out, Serial_Valid_Out, Serial_First_Out, Serial_Last_Out and Busy_Out are all 0.
  - Load_Ready_Out is forced to 0 while Reset_In=0.
- States: IDLE and SHIFT.
- Accept: a load is accepted at a rising edge when Load_Valid_In=1 and Load_Ready_Out=1. The word is captured into an internal register, so later changes on Parallel_Data_In do not affect the word in flight.
- Load_Ready_Out is combinational: 1 in IDLE, 1 in SHIFT when counter=DATA_WIDTH-1 (last-bit cycle), 0 otherwise.
- Latency: a word accepted at edge N drives its first bit at edge N (registered), so the bit is visible in cycle N+1. All DATA_WIDTH bits follow on consecutive cycles.
- IDLE -> SHIFT on accept. Counter loads 0, Serial_Valid_Out=1, Serial_First_Out=1.
- SHIFT, counter<DATA_WIDTH-1: shift one bit per edge, counter+1. Serial_First_Out=0.
- SHIFT, counter=DATA_WIDTH-1, with Serial_Last_Out=1 this cycle:
  - Accept present: reload the new word, counter=0, stay in SHIFT, Serial_First_Out=1 next cycle. There is no gap bit.
  - No accept: go to IDLE; all serial outputs are 0 next cycle.
- Load_Valid_In=1 while Load_Ready_Out=0: no accept. The producer must hold the word and valid until ready; the block never drops or corrupts the in-flight word.
- Counter width is $clog2(DATA_WIDTH). The counter never wraps past DATA_WIDTH-1.
- Bit order:
  - MSB_FIRST=1: output bit k = word[DATA_WIDTH-1-k].
  - MSB_FIRST=0: output bit k = word[k].
- Reset mid-word: the in-flight word is discarded and outputs go to 0 immediately. After release the block is in IDLE and a full new word is required; no partial resume.
- Release of Reset_In is synchronous to Clk_In at system level. The first accept is possible at the first edge after release.

Decomposition:
- Package piso_pkg holds:
  - typedef enum logic {IDLE, SHIFT} piso_state_t
  - default DATA_WIDTH
- No sub-module. The single module contains the FSM, counter and shift register. Expected RTL size is about 150 lines.

Test Plan:
- Reset, then load 8'hA5 with MSB_FIRST=1 -> Serial_Data_Out = 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles. First on bit 0, Last on bit 7, then Valid=0.
- Load 8'h3C, with 8'hC3 presented during the last-bit cycle -> 16 contiguous valid bits 0011110011000011. First pulses on cycles 1 and 9, Last on cycles 8 and 16, no gap.
- MSB_FIRST=0, load 8'h01 -> bits 1,0,0,0,0,0,0,0.
- During a word, Load_Valid_In=1 with 8'hFF on cycles 2-6 -> Load_Ready_Out=0, no accept, and the in-flight word 8'h0F is unchanged. 8'hFF is accepted only at the last bit.
- Assert Reset_In=0 after 3 bits of 8'hF0 -> outputs go to 0 immediately. After release, Load_Ready_Out=1, and a new 8'h81 serializes fully as 1,0,0,0,0,0,0,1.
- Change Parallel_Data_In to 8'h00 one cycle after accepting 8'hAA -> output is still 1,0,1,0,1,0,1,0.
